// File: rtl/perceptron_trainer_pkg.sv
// Shared definitions for the perceptron trainer: FSM state encodings,
// target decoding and width helpers used to size the arithmetic.
package perceptron_trainer_pkg;

    localparam logic [2:0] ST_IDLE      = 3'd0;
    localparam logic [2:0] ST_LOAD      = 3'd1;
    localparam logic [2:0] ST_FETCH     = 3'd2;
    localparam logic [2:0] ST_EVAL      = 3'd3;
    localparam logic [2:0] ST_UPDATE    = 3'd4;
    localparam logic [2:0] ST_EPOCH_END = 3'd5;
    localparam logic [2:0] ST_DONE      = 3'd6;

    // Target encoding: bit 1 set means -1, anything else means +1.
    function automatic logic target_is_neg(input logic [1:0] t);
        return t[1];
    endfunction

    // Width of the full-precision dot product plus bias.
    function automatic int net_width(input int x_w, input int w_w, input int n_in);
        return x_w + w_w + $clog2(n_in + 1);
    endfunction

    // Width wide enough to hold weight +/- shifted input (or bias step)
    // without overflow, so saturation can be decided exactly.
    function automatic int sum_width(input int w_w, input int x_w, input int lr_shift);
        return ((w_w > x_w + lr_shift + 1) ? w_w : (x_w + lr_shift + 1)) + 2;
    endfunction

endpackage

// File: rtl/perceptron_trainer_dot.sv
// Combinational N_IN-term dot product plus bias at full precision.
module perceptron_dot #(
    parameter int N_IN  = 2,
    parameter int X_W   = 7,
    parameter int W_W   = 14,
    parameter int NET_W = 23
) (
    input  logic [N_IN*W_W-1:0]     w,
    input  logic [N_IN*X_W-1:0]     x,
    input  logic [W_W-1:0]          b,
    output logic signed [NET_W-1:0] net
);

    logic signed [NET_W-1:0] acc_s;
    logic signed [NET_W-1:0] wi_s;
    logic signed [NET_W-1:0] xi_s;

    // Sign-extend every operand to the net width, then accumulate products.
    always_comb begin
        acc_s = {{(NET_W-W_W){b[W_W-1]}}, b};
        wi_s  = '0;
        xi_s  = '0;
        for (int i = 0; i < N_IN; i++) begin
            wi_s  = {{(NET_W-W_W){w[i*W_W+W_W-1]}}, w[i*W_W +: W_W]};
            xi_s  = {{(NET_W-X_W){x[i*X_W+X_W-1]}}, x[i*X_W +: X_W]};
            acc_s = acc_s + wi_s * xi_s;
        end
        net = acc_s;
    end

endmodule

// File: rtl/perceptron_trainer.sv
// N_IN-input perceptron trainer: loads samples into an on-chip buffer, then
// runs epochs of sign-activation perceptron learning until an error-free
// epoch or the epoch limit, holding the final weights until the next start.
module perceptron_trainer
    import perceptron_trainer_pkg::*;
#(
    parameter int N_IN      = 2,
    parameter int X_W       = 7,
    parameter int W_W       = 14,
    parameter int DEPTH     = 512,
    parameter int MAX_EPOCH = 64,
    parameter int LR_SHIFT  = 0
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             start,
    input  logic [$clog2(DEPTH+1)-1:0]       n_samples,
    input  logic                             s_valid,
    output logic                             s_ready,
    input  logic [N_IN*X_W-1:0]              s_x,
    input  logic [1:0]                       s_t,
    output logic [N_IN*W_W-1:0]              w,
    output logic [W_W-1:0]                   b,
    output logic                             busy,
    output logic                             done,
    output logic                             converged,
    output logic [$clog2(MAX_EPOCH+1)-1:0]   epoch_count,
    output logic [$clog2(DEPTH+1)-1:0]       err_count
);

    localparam int CW    = $clog2(DEPTH+1);
    localparam int EW    = $clog2(MAX_EPOCH+1);
    localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int MW    = N_IN*X_W + 2;
    localparam int NET_W = net_width(X_W, W_W, N_IN);
    localparam int SW    = sum_width(W_W, X_W, LR_SHIFT);

    localparam logic signed [SW-1:0] SAT_MAX = {{(SW-W_W+1){1'b0}}, {(W_W-1){1'b1}}};
    localparam logic signed [SW-1:0] SAT_MIN = ~SAT_MAX;
    localparam logic signed [SW-1:0] B_STEP  = {{(SW-1){1'b0}}, 1'b1} << LR_SHIFT;

    // Clamp a wide signed sum into the signed weight range.
    function automatic logic [W_W-1:0] sat_w(input logic signed [SW-1:0] v);
        logic [W_W-1:0] r;
        if (v > SAT_MAX) begin
            r = SAT_MAX[W_W-1:0];
        end else if (v < SAT_MIN) begin
            r = SAT_MIN[W_W-1:0];
        end else begin
            r = v[W_W-1:0];
        end
        return r;
    endfunction

    logic [2:0]          state_r;
    logic [CW-1:0]       idx_r;
    logic [CW-1:0]       n_r;
    logic [CW-1:0]       ep_err_r;
    logic [CW-1:0]       err_r;
    logic [EW-1:0]       epoch_r;
    logic [N_IN*W_W-1:0] w_r;
    logic [W_W-1:0]      b_r;
    logic                conv_r;
    logic [MW-1:0]       rd_r;
    logic [MW-1:0]       mem [DEPTH];

    logic signed [NET_W-1:0] net_s;
    logic                    t_neg_s;
    logic                    mis_s;
    logic                    last_s;
    logic                    we_s;
    logic [CW-1:0]           n_clamp_s;
    logic [EW-1:0]           epoch_nx_s;
    logic [N_IN*W_W-1:0]     w_upd_s;
    logic [W_W-1:0]          b_upd_s;
    logic signed [SW-1:0]    wx_s;
    logic signed [SW-1:0]    xx_s;
    logic signed [SW-1:0]    sum_s;
    logic signed [SW-1:0]    bx_s;
    logic signed [SW-1:0]    bsum_s;

    perceptron_dot #(
        .N_IN  (N_IN),
        .X_W   (X_W),
        .W_W   (W_W),
        .NET_W (NET_W)
    ) u_dot (
        .w   (w_r),
        .x   (rd_r[N_IN*X_W-1:0]),
        .b   (b_r),
        .net (net_s)
    );

    assign t_neg_s    = target_is_neg(rd_r[MW-1:MW-2]);
    assign mis_s      = (net_s[NET_W-1] != t_neg_s);
    assign last_s     = (idx_r == (n_r - CW'(1'b1)));
    assign we_s       = (state_r == ST_LOAD) && s_valid;
    assign n_clamp_s  = (n_samples > CW'(DEPTH)) ? CW'(DEPTH) : n_samples;
    assign epoch_nx_s = epoch_r + EW'(1'b1);

    // Candidate saturated weights and bias for a misclassified sample.
    always_comb begin
        w_upd_s = w_r;
        wx_s    = '0;
        xx_s    = '0;
        sum_s   = '0;
        for (int i = 0; i < N_IN; i++) begin
            wx_s = {{(SW-W_W){w_r[i*W_W+W_W-1]}}, w_r[i*W_W +: W_W]};
            xx_s = {{(SW-X_W){rd_r[i*X_W+X_W-1]}}, rd_r[i*X_W +: X_W]} << LR_SHIFT;
            if (t_neg_s) begin
                sum_s = wx_s - xx_s;
            end else begin
                sum_s = wx_s + xx_s;
            end
            w_upd_s[i*W_W +: W_W] = sat_w(sum_s);
        end
        bx_s = {{(SW-W_W){b_r[W_W-1]}}, b_r};
        if (t_neg_s) begin
            bsum_s = bx_s - B_STEP;
        end else begin
            bsum_s = bx_s + B_STEP;
        end
        b_upd_s = sat_w(bsum_s);
    end

    // Sample buffer: written on LOAD handshakes, read registered in FETCH.
    always_ff @(posedge clk) begin
        if (we_s) begin
            mem[idx_r[AW-1:0]] <= {s_t, s_x};
        end
        if (state_r == ST_FETCH) begin
            rd_r <= mem[idx_r[AW-1:0]];
        end
    end

    // Training FSM with weight, bias and statistics registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r  <= ST_IDLE;
            idx_r    <= '0;
            n_r      <= '0;
            ep_err_r <= '0;
            err_r    <= '0;
            epoch_r  <= '0;
            w_r      <= '0;
            b_r      <= '0;
            conv_r   <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE, ST_DONE: begin
                    if (start) begin
                        w_r      <= '0;
                        b_r      <= '0;
                        epoch_r  <= '0;
                        err_r    <= '0;
                        ep_err_r <= '0;
                        idx_r    <= '0;
                        n_r      <= n_clamp_s;
                        if (n_clamp_s == '0) begin
                            conv_r  <= 1'b1;
                            state_r <= ST_DONE;
                        end else begin
                            conv_r  <= 1'b0;
                            state_r <= ST_LOAD;
                        end
                    end
                end
                ST_LOAD: begin
                    if (s_valid) begin
                        if (last_s) begin
                            idx_r   <= '0;
                            state_r <= ST_FETCH;
                        end else begin
                            idx_r <= idx_r + CW'(1'b1);
                        end
                    end
                end
                ST_FETCH: begin
                    state_r <= ST_EVAL;
                end
                ST_EVAL: begin
                    if (mis_s) begin
                        state_r <= ST_UPDATE;
                    end else if (last_s) begin
                        state_r <= ST_EPOCH_END;
                    end else begin
                        idx_r   <= idx_r + CW'(1'b1);
                        state_r <= ST_FETCH;
                    end
                end
                ST_UPDATE: begin
                    w_r      <= w_upd_s;
                    b_r      <= b_upd_s;
                    ep_err_r <= ep_err_r + CW'(1'b1);
                    if (last_s) begin
                        state_r <= ST_EPOCH_END;
                    end else begin
                        idx_r   <= idx_r + CW'(1'b1);
                        state_r <= ST_FETCH;
                    end
                end
                ST_EPOCH_END: begin
                    epoch_r  <= epoch_nx_s;
                    err_r    <= ep_err_r;
                    ep_err_r <= '0;
                    idx_r    <= '0;
                    if (ep_err_r == '0) begin
                        conv_r  <= 1'b1;
                        state_r <= ST_DONE;
                    end else if (epoch_nx_s == EW'(MAX_EPOCH)) begin
                        conv_r  <= 1'b0;
                        state_r <= ST_DONE;
                    end else begin
                        state_r <= ST_FETCH;
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

    assign s_ready     = (state_r == ST_LOAD);
    assign busy        = (state_r != ST_IDLE) && (state_r != ST_DONE);
    assign done        = (state_r == ST_DONE);
    assign w           = w_r;
    assign b           = b_r;
    assign converged   = conv_r;
    assign epoch_count = epoch_r;
    assign err_count   = err_r;

endmodule
